// File: rtl/tlul_intg_arb.sv
// rtl/tlul_intg_arb.sv - N-to-1 TL-UL A-channel arbiter sharing one device port and one integrity checker
// Single outstanding transaction; integrity failures are answered locally with an error response.
module tlul_intg_arb #(
  parameter int NumHosts  = 4,
  parameter int PayloadW  = 108,
  parameter int RspW      = 66,
  parameter bit LockOnErr = 1'b1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NumHosts-1:0]          host_a_valid_i,
  input  logic [NumHosts*PayloadW-1:0] host_a_payload_i,
  output logic [NumHosts-1:0]          host_a_ready_o,
  output logic [NumHosts-1:0]          host_d_valid_o,
  input  logic [NumHosts-1:0]          host_d_ready_i,
  output logic [RspW-1:0]              host_d_payload_o,
  output logic                         host_d_error_o,
  output logic [PayloadW-1:0]          chk_payload_o,
  input  logic                         chk_err_i,
  output logic                         dev_a_valid_o,
  output logic [PayloadW-1:0]          dev_a_payload_o,
  input  logic                         dev_a_ready_i,
  input  logic                         dev_d_valid_i,
  input  logic [RspW-1:0]              dev_d_payload_i,
  input  logic                         dev_d_error_i,
  output logic                         dev_d_ready_o,
  output logic                         locked_o,
  output logic [7:0]                   err_cnt_o
);

  localparam int IdxW = (NumHosts > 1) ? $clog2(NumHosts) : 1;

  typedef enum logic [2:0] {IDLE, CHK, FWD, RSP, ERR_RSP} state_e;

  state_e              state_q;
  logic [IdxW-1:0]     ptr_q;
  logic [IdxW-1:0]     gnt_q;
  logic [PayloadW-1:0] hold_q;
  logic                locked_q;
  logic [7:0]          err_cnt_q;
  logic [7:0]          err_cnt_d;

  logic [IdxW-1:0]     cand;
  logic [IdxW-1:0]     arb_idx;
  logic                arb_found;
  logic [NumHosts-1:0] arb_oh;
  logic [NumHosts-1:0] gnt_oh;

  // Round-robin search starting just after the last granted host.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NumHosts; i++) begin
      cand = IdxW'((int'(ptr_q) + i) % NumHosts);
      if (!arb_found && host_a_valid_i[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  assign arb_oh    = NumHosts'(1) << arb_idx;
  assign gnt_oh    = NumHosts'(1) << gnt_q;
  assign err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      ptr_q     <= IdxW'(NumHosts - 1);
      gnt_q     <= '0;
      hold_q    <= '0;
      locked_q  <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_found) begin
            hold_q  <= host_a_payload_i[arb_idx*PayloadW +: PayloadW];
            gnt_q   <= arb_idx;
            ptr_q   <= arb_idx;
            state_q <= CHK;
          end
        end
        CHK: begin
          if (chk_err_i) begin
            err_cnt_q <= err_cnt_d;
            if (LockOnErr) locked_q <= 1'b1;
            state_q <= ERR_RSP;
          end else if (locked_q) begin
            state_q <= ERR_RSP;
          end else begin
            state_q <= FWD;
          end
        end
        FWD: begin
          if (dev_a_ready_i) state_q <= RSP;
        end
        RSP: begin
          if (dev_d_valid_i && host_d_ready_i[gnt_q]) state_q <= IDLE;
        end
        ERR_RSP: begin
          if (host_d_ready_i[gnt_q]) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Ready is masked during reset so no host believes its request was taken.
  assign host_a_ready_o   = (state_q == IDLE && arb_found && !rst_i) ? arb_oh : '0;
  assign host_d_valid_o   = ((state_q == RSP && dev_d_valid_i) || state_q == ERR_RSP) ? gnt_oh : '0;
  assign host_d_payload_o = (state_q == RSP) ? dev_d_payload_i : '0;
  assign host_d_error_o   = (state_q == RSP) ? dev_d_error_i : (state_q == ERR_RSP);
  assign dev_d_ready_o    = (state_q == RSP) && host_d_ready_i[gnt_q];
  assign dev_a_valid_o    = (state_q == FWD);
  assign dev_a_payload_o  = hold_q;
  assign chk_payload_o    = hold_q;
  assign locked_o         = locked_q;
  assign err_cnt_o        = err_cnt_q;

endmodule

// File: tb/tb_tlul_intg_arb.sv
// tb/tb_tlul_intg_arb.sv - directed self-checking bench for tlul_intg_arb
// Instance u_dut locks on error; u_nolock exercises counter saturation without locking.
module tb_tlul_intg_arb;

  localparam int NH = 4;
  localparam int PW = 108;
  localparam int RW = 66;

  logic            clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic            rst;
  logic [NH-1:0]   a_valid;
  logic [NH*PW-1:0] a_payload;
  logic [NH-1:0]   a_ready;
  logic [NH-1:0]   d_valid;
  logic [NH-1:0]   d_ready;
  logic [RW-1:0]   d_payload;
  logic            d_error;
  logic [PW-1:0]   chk_payload;
  logic            chk_err;
  logic            dev_a_valid;
  logic [PW-1:0]   dev_a_payload;
  logic            dev_a_ready;
  logic            dev_d_valid;
  logic [RW-1:0]   dev_d_payload;
  logic            dev_d_error;
  logic            dev_d_ready;
  logic            locked;
  logic [7:0]      err_cnt;

  logic            b_rst;
  logic [NH-1:0]   b_a_valid;
  logic [NH*PW-1:0] b_a_payload;
  logic [NH-1:0]   b_a_ready;
  logic [NH-1:0]   b_d_valid;
  logic [NH-1:0]   b_d_ready;
  logic [RW-1:0]   b_d_payload;
  logic            b_d_error;
  logic [PW-1:0]   b_chk_payload;
  logic            b_chk_err;
  logic            b_dev_a_valid;
  logic [PW-1:0]   b_dev_a_payload;
  logic            b_dev_d_ready;
  logic            b_locked;
  logic [7:0]      b_err_cnt;

  tlul_intg_arb #(.NumHosts(NH), .PayloadW(PW), .RspW(RW), .LockOnErr(1'b1)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .host_a_valid_i(a_valid), .host_a_payload_i(a_payload), .host_a_ready_o(a_ready),
    .host_d_valid_o(d_valid), .host_d_ready_i(d_ready), .host_d_payload_o(d_payload),
    .host_d_error_o(d_error), .chk_payload_o(chk_payload), .chk_err_i(chk_err),
    .dev_a_valid_o(dev_a_valid), .dev_a_payload_o(dev_a_payload), .dev_a_ready_i(dev_a_ready),
    .dev_d_valid_i(dev_d_valid), .dev_d_payload_i(dev_d_payload), .dev_d_error_i(dev_d_error),
    .dev_d_ready_o(dev_d_ready), .locked_o(locked), .err_cnt_o(err_cnt)
  );

  tlul_intg_arb #(.NumHosts(NH), .PayloadW(PW), .RspW(RW), .LockOnErr(1'b0)) u_nolock (
    .clk_i(clk), .rst_i(b_rst),
    .host_a_valid_i(b_a_valid), .host_a_payload_i(b_a_payload), .host_a_ready_o(b_a_ready),
    .host_d_valid_o(b_d_valid), .host_d_ready_i(b_d_ready), .host_d_payload_o(b_d_payload),
    .host_d_error_o(b_d_error), .chk_payload_o(b_chk_payload), .chk_err_i(b_chk_err),
    .dev_a_valid_o(b_dev_a_valid), .dev_a_payload_o(b_dev_a_payload), .dev_a_ready_i(1'b1),
    .dev_d_valid_i(1'b0), .dev_d_payload_i('0), .dev_d_error_i(1'b0),
    .dev_d_ready_o(b_dev_d_ready), .locked_o(b_locked), .err_cnt_o(b_err_cnt)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic set_pl(input int h, input logic [PW-1:0] v);
    a_payload[h*PW +: PW] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  int rr_exp [6] = '{0, 2, 3, 0, 2, 3};

  initial begin
    rst = 1'b1; a_valid = '0; a_payload = '0; d_ready = '0; chk_err = 1'b0;
    dev_a_ready = 1'b0; dev_d_valid = 1'b0; dev_d_payload = '0; dev_d_error = 1'b0;
    b_rst = 1'b1; b_a_valid = 4'b0001; b_a_payload = '0; b_d_ready = 4'b1111; b_chk_err = 1'b1;

    do_reset();
    settle();
    check("rst_a_ready", a_ready, 4'b0000);
    check("rst_d_valid", d_valid, 4'b0000);
    check("rst_dev_a_valid", dev_a_valid, 1'b0);
    check("rst_dev_d_ready", dev_d_ready, 1'b0);
    check("rst_chk_payload", chk_payload, 0);
    check("rst_locked", locked, 1'b0);
    check("rst_err_cnt", err_cnt, 8'd0);

    // Host 1 alone, clean request, forwarded and answered.
    cyc();
    a_valid = 4'b0010; set_pl(1, 108'hA5); dev_a_ready = 1'b1; d_ready = 4'b1111;
    settle();
    check("t1_a_ready", a_ready, 4'b0010);
    cyc();
    a_valid = '0;
    settle();
    check("t1_chk_payload", chk_payload, 108'hA5);
    check("t1_no_early_dev_a", dev_a_valid, 1'b0);
    check("t1_a_ready_busy", a_ready, 4'b0000);
    cyc();
    settle();
    check("t1_dev_a_valid", dev_a_valid, 1'b1);
    check("t1_dev_a_payload", dev_a_payload, 108'hA5);
    cyc();
    dev_d_valid = 1'b1; dev_d_payload = 66'h1234; dev_d_error = 1'b0;
    settle();
    check("t1_dev_a_drop", dev_a_valid, 1'b0);
    check("t1_d_valid", d_valid, 4'b0010);
    check("t1_d_payload", d_payload, 66'h1234);
    check("t1_d_error", d_error, 1'b0);
    check("t1_dev_d_ready", dev_d_ready, 1'b1);
    cyc();
    dev_d_valid = 1'b0;
    settle();
    check("t1_idle_d_valid", d_valid, 4'b0000);

    // Round robin among hosts 0, 2, 3 from reset priority.
    do_reset();
    for (int h = 0; h < NH; h++) set_pl(h, PW'(32'h100 + h));
    a_valid = 4'b1101; dev_a_ready = 1'b1; d_ready = 4'b1111;
    dev_d_valid = 1'b1; dev_d_payload = 66'h55;
    for (int k = 0; k < 6; k++) begin
      settle();
      check("rr_grant", a_ready, 4'b0001 << rr_exp[k]);
      cyc();
      settle();
      check("rr_chk_payload", chk_payload, 32'h100 + rr_exp[k]);
      check("rr_stray_d_ready", dev_d_ready, 1'b0);
      check("rr_stray_d_valid", d_valid, 4'b0000);
      cyc();
      settle();
      check("rr_dev_a_valid", dev_a_valid, 1'b1);
      cyc();
      settle();
      check("rr_d_valid", d_valid, 4'b0001 << rr_exp[k]);
      cyc();
    end
    a_valid = '0; dev_d_valid = 1'b0;

    // Host 2 fails integrity: local error response, counter and lock.
    cyc();
    a_valid = 4'b0100;
    settle();
    check("e_a_ready", a_ready, 4'b0100);
    cyc();
    a_valid = '0; chk_err = 1'b1; d_ready = 4'b0000;
    settle();
    cyc();
    chk_err = 1'b0;
    settle();
    check("e_dev_a_valid", dev_a_valid, 1'b0);
    check("e_d_valid", d_valid, 4'b0100);
    check("e_d_error", d_error, 1'b1);
    check("e_d_payload", d_payload, 0);
    check("e_err_cnt", err_cnt, 8'd1);
    check("e_locked", locked, 1'b1);
    check("e_dev_d_ready", dev_d_ready, 1'b0);
    cyc();
    settle();
    check("e_d_valid_hold", d_valid, 4'b0100);
    d_ready = 4'b1111;
    cyc();
    settle();
    check("e_d_valid_done", d_valid, 4'b0000);

    // Locked port: clean host 0 request is refused locally.
    a_valid = 4'b0001;
    settle();
    check("l_a_ready", a_ready, 4'b0001);
    cyc();
    a_valid = '0;
    settle();
    cyc();
    settle();
    check("l_dev_a_valid", dev_a_valid, 1'b0);
    check("l_d_valid", d_valid, 4'b0001);
    check("l_d_error", d_error, 1'b1);
    check("l_err_cnt", err_cnt, 8'd1);
    check("l_locked", locked, 1'b1);
    cyc();
    settle();
    check("l_dev_a_after", dev_a_valid, 1'b0);

    // Device stalls A for 5 cycles, host stalls D for 3 cycles.
    do_reset();
    check("s_lock_cleared", locked, 1'b0);
    a_valid = 4'b1000; set_pl(3, 108'hC0FFEE); dev_a_ready = 1'b0; d_ready = 4'b0000;
    cyc();
    a_valid = '0;
    cyc();
    for (int i = 0; i < 5; i++) begin
      settle();
      check("s_a_hold_valid", dev_a_valid, 1'b1);
      check("s_a_hold_payload", dev_a_payload, 108'hC0FFEE);
      cyc();
    end
    dev_a_ready = 1'b1;
    settle();
    check("s_a_valid_last", dev_a_valid, 1'b1);
    cyc();
    dev_a_ready = 1'b0; dev_d_valid = 1'b1; dev_d_payload = 66'hBEEF; dev_d_error = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("s_d_hold_valid", d_valid, 4'b1000);
      check("s_d_hold_payload", d_payload, 66'hBEEF);
      check("s_d_hold_ready", dev_d_ready, 1'b0);
      check("s_dev_a_once", dev_a_valid, 1'b0);
      cyc();
    end
    d_ready = 4'b1111;
    settle();
    check("s_d_ready_hs", dev_d_ready, 1'b1);
    check("s_d_error", d_error, 1'b1);
    cyc();
    settle();
    check("s_d_once_valid", d_valid, 4'b0000);
    check("s_d_once_ready", dev_d_ready, 1'b0);
    dev_d_valid = 1'b0; dev_d_error = 1'b0;

    // Reset asserted while in FWD with a pending device response.
    a_valid = 4'b0010; set_pl(1, 108'h77); dev_a_ready = 1'b0;
    cyc();
    a_valid = '0;
    cyc();
    settle();
    check("r_fwd_valid", dev_a_valid, 1'b1);
    rst = 1'b1; dev_d_valid = 1'b1;
    cyc();
    settle();
    check("r_dev_a_valid", dev_a_valid, 1'b0);
    check("r_dev_a_payload", dev_a_payload, 0);
    check("r_chk_payload", chk_payload, 0);
    check("r_d_valid", d_valid, 4'b0000);
    check("r_dev_d_ready", dev_d_ready, 1'b0);
    check("r_a_ready", a_ready, 4'b0000);
    check("r_locked", locked, 1'b0);
    check("r_err_cnt", err_cnt, 8'd0);
    rst = 1'b0; dev_d_valid = 1'b0;

    // Non-locking instance: continuous integrity errors saturate the counter.
    b_rst = 1'b0;
    repeat (920) cyc();
    settle();
    check("n_err_cnt_sat", b_err_cnt, 8'd255);
    check("n_locked", b_locked, 1'b0);
    check("n_dev_a_valid", b_dev_a_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
